mem_stage: RTL and testbench
============================

# mem_stage

Pipeline stage directly downstream of the execute stage. It consumes the instruction held in the execute stage's output registers and issues data-SRAM load/store requests over an SRAM-like `req`/`addr_ok`/`data_ok` interface. It collects multiplier and divider responses, aligns and extends load data, and registers one result per instruction toward write-back. It also reports exceptions upstream and drains any memory request orphaned by a flush.

## Interface
Parameters:
- `RESET_PC`, `32'h1c000000`: reset value of `PC_out`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1
  - `rst` in 1
- Pipeline handshake and flush:
  - `in_valid` in 1; `in_ready` out 1; `out_valid` out 1; `out_ready` in 1: pipeline handshake.
  - `ex_flush`, `ertn_flush` in 1: flush the in-stage instruction.
  - `this_exception` out 1: in-stage exception or ertn; feeds the execute stage's `next_exception`.
- Instruction fields from the execute stage:
  - `result` in 32: ALU/CSR result; this is the memory address for memory ops.
  - `PC` in 32.
  - `mem_op` in 8: one-hot.
    - [0] ld.b, [1] ld.h, [2] ld.w, [3] st.b
    - [4] st.h, [5] ld.bu, [6] ld.hu, [7] st.w
  - `mul_op` in 3: one-hot. [0] low word, [1]/[2] high word.
  - `div_op` in 4: one-hot. [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu.
  - `res_from_mul`, `res_from_div`, `res_from_mem`, `res_from_csr`, `gr_we`, `mem_we` in 1.
  - `dest` in 5; `rkd_value` in 32 (store data).
  - `has_exception` in 1; `ecode` in 6; `esubcode` in 9; `exception_maddr` in 32; `ertn` in 1.
- Data-SRAM interface:
  - `data_req` out 1; `data_wr` out 1; `data_size` out 2; `data_wstrb` out 4.
  - `data_addr` out 32; `data_wdata` out 32.
  - `data_addr_ok` in 1; `data_data_ok` in 1; `data_rdata` in 32.
- Multiplier response: `mul_resp_valid` in 1; `mul_resp_ready` out 1; `mul_resp` in 64.
- Divider response: `div_resp_valid` in 1; `div_resp_ready` out 1; `div_quot` in 32; `div_rem` in 32.
- Outputs to write-back (all registered):
  - `PC_out` 32; `final_result` 32; `gr_we_out` 1; `dest_out` 5.
  - `has_exception_out` 1; `ecode_out` 6; `esubcode_out` 9; `exception_maddr_out` 32; `ertn_out` 1.

## Operation
- `flush` = `ex_flush | ertn_flush`.
- `this_exception` = `in_valid & (has_exception | ertn)`.
- `is_mem` = `|mem_op`.
- `issue` = `in_valid & is_mem & !this_exception & !flush & state==IDLE`.
- Request signals:
  - `data_req` = `issue`.
  - `data_wr` = `mem_we`.
  - `data_addr` = `result`.
- `data_size`: 0 for byte ops, 1 for half ops, 2 for word ops.
- Store data and strobes:
  - `data_wdata`: byte replicated ×4, half replicated ×2, or word.
  - `data_wstrb`: st.b gives `4'b0001<<addr[1:0]`; st.h gives `4'b0011<<addr[1:0]`; st.w gives `4'hf`; loads give 0.
- FSM states:
  - IDLE: no outstanding request. `issue & data_addr_ok` → WAIT.
  - WAIT: request accepted, waiting for data.
    - `data_data_ok & !out_ready` → HOLD (capture `data_rdata`).
    - `data_data_ok & out_ready` → IDLE.
    - `flush` without `data_data_ok` → DRAIN.
  - HOLD: data buffered. `out_ready` → IDLE; `flush` → IDLE.
  - DRAIN: flushed request outstanding; `in_ready`=0. `data_data_ok` (discarded) → IDLE.
- `ready_go`:
  - 1 when any of: `!in_valid`, `flush`, `this_exception`, or all of the following hold:
    - memory condition: `!is_mem`, or (WAIT & `data_data_ok`), or HOLD.
    - multiplier condition: `!res_from_mul` or `mul_resp_valid`.
    - divider condition: `!res_from_div` or `div_resp_valid`.
- `in_ready` = `!rst & state!=DRAIN & (!in_valid | ready_go & out_ready)`.
- `mul_resp_ready` = `in_valid & res_from_mul & out_ready & !flush & !this_exception`. `div_resp_ready` is formed the same way.
- The multiplier and divider receive `flush` directly and discard their own in-flight work; this block never drains them.
- Load alignment: select the byte or half at `addr[1:0]` from the current `data_rdata` or the HOLD buffer. ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend.
- `final_result` priority:
  1. load data.
  2. mul: `mul_op[0]` gives `mul_resp[31:0]`, else `mul_resp[63:32]`.
  3. div: div ops give `div_quot`, mod ops give `div_rem`.
  4. otherwise `result`.
- Exception fields, `PC`, `dest`, `ertn`, and `exception_maddr` pass through registered. `gr_we_out` = `gr_we & !has_exception`.

## Timing
- Reset:
  - `out_valid`, `gr_we_out`, `has_exception_out`, `ertn_out` = 0.
  - `PC_out` = `RESET_PC`.
  - All other outputs = 0; state = IDLE.
- Output registers load when `in_valid & ready_go & out_ready`.
- `out_valid` updates when `out_ready`: `out_valid <= in_valid & ready_go & !flush`.
- Latency with `addr_ok` and `data_ok` each one cycle after request: request in cycle N, `data_ok` in N+1, `out_valid` high in N+2.
- Simultaneous events:
  - `flush` with `data_addr_ok` in IDLE cannot occur, because `issue` is gated by `flush`.
  - `flush` with `data_data_ok` in WAIT: data is discarded, state → IDLE.
- Exactly one `data_data_ok` is consumed per accepted request, including flushed ones.
- Reset mid-request forces IDLE; the memory side is reset together with this block.

## Structure
- Shared package holds:
  - `mem_op` bit indices.
  - FSM state encoding (2-bit: IDLE, WAIT, HOLD, DRAIN).
  - `data_size` encodings and `RESET_PC`.
- One natural sub-module, `load_align`: combinational extract/extend of `rdata` by `mem_op` and `addr[1:0]`.

## Test plan
- ld.b at `0x1c0_0003`, `rdata=0x80_12_34_56` → `final_result=0xffffff80`, `out_valid` at N+2.
- st.h at addr[1:0]=2, `rkd_value=0x0000abcd` → `data_wstrb=4'b1100`, `data_wdata=0xabcdabcd`, `data_size=1`.
- `data_data_ok` while `out_ready`=0 for 3 cycles → HOLD; `final_result` captured from the buffer when `out_ready` rises.
- `ertn_flush` in WAIT → DRAIN with `in_ready`=0. The next `data_data_ok` (0xdead_beef) is dropped, `out_valid` stays 0, and state → IDLE.
- `has_exception=1`, `mem_op`=ld.w → no `data_req`. `this_exception`=1; `ecode` is passed through one cycle later.
- mulh.wu with `mul_resp=0x00000001_00000000`, `mul_resp_valid` delayed 4 cycles → `in_ready`=0 until valid, then `final_result=0x00000001`.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: mem_op bit positions, FSM encoding,
// SRAM transfer-size codes and the default reset PC.
package mem_stage_pkg;

    localparam int OP_LD_B  = 0;
    localparam int OP_LD_H  = 1;
    localparam int OP_LD_W  = 2;
    localparam int OP_ST_B  = 3;
    localparam int OP_ST_H  = 4;
    localparam int OP_LD_BU = 5;
    localparam int OP_LD_HU = 6;
    localparam int OP_ST_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte or halfword from a load word and sign- or
// zero-extends it; word loads pass through untouched.
module mem_stage_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        is_byte,
    input  logic        is_half,
    input  logic        sign_ext,
    output logic [31:0] load_data
);

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        if (is_byte)
            load_data = ext8(byte_sel, sign_ext);
        else if (is_half)
            load_data = ext16(half_sel, sign_ext);
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-SRAM requests, merges load/mul/div results
// and registers one result per instruction toward write-back.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        ex_flush,
    input  logic        ertn_flush,
    output logic        this_exception,
    input  logic [31:0] result,
    input  logic [31:0] PC,
    input  logic [7:0]  mem_op,
    input  logic [2:0]  mul_op,
    input  logic [3:0]  div_op,
    input  logic        res_from_mul,
    input  logic        res_from_div,
    input  logic        res_from_mem,
    input  logic        res_from_csr,
    input  logic        gr_we,
    input  logic        mem_we,
    input  logic [4:0]  dest,
    input  logic [31:0] rkd_value,
    input  logic        has_exception,
    input  logic [5:0]  ecode,
    input  logic [8:0]  esubcode,
    input  logic [31:0] exception_maddr,
    input  logic        ertn,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        mul_resp_valid,
    output logic        mul_resp_ready,
    input  logic [63:0] mul_resp,
    input  logic        div_resp_valid,
    output logic        div_resp_ready,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] PC_out,
    output logic [31:0] final_result,
    output logic        gr_we_out,
    output logic [4:0]  dest_out,
    output logic        has_exception_out,
    output logic [5:0]  ecode_out,
    output logic [8:0]  esubcode_out,
    output logic [31:0] exception_maddr_out,
    output logic        ertn_out
);

    state_t      state, state_nxt;
    logic        flush, is_mem, issue, ready_go, load_fire;
    logic        mem_cond, mul_cond, div_cond;
    logic        is_byte_op, is_half_op;
    logic        mul_pick_lo, div_pick_rem;
    logic [31:0] rdata_hold_p1, load_src, load_data, result_nxt;
    logic        unused_csr;

    // CSR results already arrive merged into result, so the flag is not needed here.
    assign unused_csr = res_from_csr;

    assign flush          = ex_flush | ertn_flush;
    assign this_exception = in_valid & (has_exception | ertn);
    assign is_mem         = |mem_op;
    assign issue          = in_valid & is_mem & !this_exception & !flush & (state == ST_IDLE);

    assign is_byte_op = mem_op[OP_LD_B] | mem_op[OP_LD_BU] | mem_op[OP_ST_B];
    assign is_half_op = mem_op[OP_LD_H] | mem_op[OP_LD_HU] | mem_op[OP_ST_H];

    assign data_req  = issue;
    assign data_wr   = mem_we;
    assign data_addr = result;
    assign data_size = is_byte_op ? SIZE_BYTE : (is_half_op ? SIZE_HALF : SIZE_WORD);

    always_comb begin
        data_wdata = rkd_value;
        data_wstrb = 4'h0;
        if (is_byte_op)
            data_wdata = {4{rkd_value[7:0]}};
        else if (is_half_op)
            data_wdata = {2{rkd_value[15:0]}};
        if (mem_op[OP_ST_B])
            data_wstrb = 4'b0001 << result[1:0];
        else if (mem_op[OP_ST_H])
            data_wstrb = 4'b0011 << result[1:0];
        else if (mem_op[OP_ST_W])
            data_wstrb = 4'hf;
    end

    assign mem_cond = !is_mem | ((state == ST_WAIT) & data_data_ok) | (state == ST_HOLD);
    assign mul_cond = !res_from_mul | mul_resp_valid;
    assign div_cond = !res_from_div | div_resp_valid;
    assign ready_go = !in_valid | flush | this_exception | (mem_cond & mul_cond & div_cond);

    assign in_ready       = !rst & (state != ST_DRAIN) & (!in_valid | (ready_go & out_ready));
    assign mul_resp_ready = in_valid & res_from_mul & out_ready & !flush & !this_exception;
    assign div_resp_ready = in_valid & res_from_div & out_ready & !flush & !this_exception;
    assign load_fire      = in_valid & ready_go & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue & data_addr_ok) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (data_data_ok)
                    state_nxt = (flush | out_ready) ? ST_IDLE : ST_HOLD;
                else if (flush)
                    state_nxt = ST_DRAIN;
            end
            ST_HOLD:  if (out_ready | flush) state_nxt = ST_IDLE;
            ST_DRAIN: if (data_data_ok) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Stage p1: buffer load data that arrived while write-back was stalled.
    always_ff @(posedge clk) begin
        if ((state == ST_WAIT) & data_data_ok & !out_ready & !flush)
            rdata_hold_p1 <= data_rdata;
    end

    assign load_src = (state == ST_HOLD) ? rdata_hold_p1 : data_rdata;

    mem_stage_load_align u_load_align (
        .rdata     (load_src),
        .addr_lo   (result[1:0]),
        .is_byte   (mem_op[OP_LD_B] | mem_op[OP_LD_BU]),
        .is_half   (mem_op[OP_LD_H] | mem_op[OP_LD_HU]),
        .sign_ext  (mem_op[OP_LD_B] | mem_op[OP_LD_H]),
        .load_data (load_data)
    );

    assign mul_pick_lo  = mul_op[0] | !(mul_op[1] | mul_op[2]);
    assign div_pick_rem = (div_op[1] | div_op[3]) & !(div_op[0] | div_op[2]);

    always_comb begin
        result_nxt = result;
        if (res_from_mem)
            result_nxt = load_data;
        else if (res_from_mul)
            result_nxt = mul_pick_lo ? mul_resp[31:0] : mul_resp[63:32];
        else if (res_from_div)
            result_nxt = div_pick_rem ? div_rem : div_quot;
    end

    // Stage p2: registered write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_out              <= RESET_PC;
            final_result        <= 32'h0;
            gr_we_out           <= 1'b0;
            dest_out            <= 5'h0;
            has_exception_out   <= 1'b0;
            ecode_out           <= 6'h0;
            esubcode_out        <= 9'h0;
            exception_maddr_out <= 32'h0;
            ertn_out            <= 1'b0;
        end else if (load_fire) begin
            PC_out              <= PC;
            final_result        <= result_nxt;
            gr_we_out           <= gr_we & !has_exception;
            dest_out            <= dest;
            has_exception_out   <= has_exception;
            ecode_out           <= ecode;
            esubcode_out        <= esubcode;
            exception_maddr_out <= exception_maddr;
            ertn_out            <= ertn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_valid <= 1'b0;
        else if (out_ready)
            out_valid <= in_valid & ready_go & !flush;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: drives the execute-side and SRAM-side
// handshakes by hand and compares registered outputs against fixed values.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        ex_flush, ertn_flush, this_exception;
    logic [31:0] result, PC;
    logic [7:0]  mem_op;
    logic [2:0]  mul_op;
    logic [3:0]  div_op;
    logic        res_from_mul, res_from_div, res_from_mem, res_from_csr, gr_we, mem_we;
    logic [4:0]  dest;
    logic [31:0] rkd_value;
    logic        has_exception;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] exception_maddr;
    logic        ertn;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mul_resp_valid, mul_resp_ready;
    logic [63:0] mul_resp;
    logic        div_resp_valid, div_resp_ready;
    logic [31:0] div_quot, div_rem;
    logic [31:0] PC_out, final_result;
    logic        gr_we_out;
    logic [4:0]  dest_out;
    logic        has_exception_out;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;
    logic [31:0] exception_maddr_out;
    logic        ertn_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .ex_flush(ex_flush), .ertn_flush(ertn_flush), .this_exception(this_exception),
        .result(result), .PC(PC), .mem_op(mem_op), .mul_op(mul_op), .div_op(div_op),
        .res_from_mul(res_from_mul), .res_from_div(res_from_div), .res_from_mem(res_from_mem),
        .res_from_csr(res_from_csr), .gr_we(gr_we), .mem_we(mem_we), .dest(dest),
        .rkd_value(rkd_value), .has_exception(has_exception), .ecode(ecode),
        .esubcode(esubcode), .exception_maddr(exception_maddr), .ertn(ertn),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready), .mul_resp(mul_resp),
        .div_resp_valid(div_resp_valid), .div_resp_ready(div_resp_ready),
        .div_quot(div_quot), .div_rem(div_rem),
        .PC_out(PC_out), .final_result(final_result), .gr_we_out(gr_we_out), .dest_out(dest_out),
        .has_exception_out(has_exception_out), .ecode_out(ecode_out), .esubcode_out(esubcode_out),
        .exception_maddr_out(exception_maddr_out), .ertn_out(ertn_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; out_ready = 1; ex_flush = 0; ertn_flush = 0;
        result = 0; PC = 0; mem_op = 0; mul_op = 0; div_op = 0;
        res_from_mul = 0; res_from_div = 0; res_from_mem = 0; res_from_csr = 0;
        gr_we = 0; mem_we = 0; dest = 0; rkd_value = 0;
        has_exception = 0; ecode = 0; esubcode = 0; exception_maddr = 0; ertn = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        mul_resp_valid = 0; mul_resp = 0; div_resp_valid = 0; div_quot = 0; div_rem = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Issue in cycle N (addr_ok same cycle), data_ok in N+1, result visible in N+2.
    task automatic load_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        @(posedge clk); #1;
        in_valid = 1; mem_op = op; res_from_mem = 1; gr_we = 1; dest = 5'd7;
        result = addr; PC = 32'h1c00_1000; data_addr_ok = 1;
        @(negedge clk);
        chk({tag, "_req"}, {31'h0, data_req}, 32'h1);
        @(posedge clk); #1;
        data_addr_ok = 0; data_data_ok = 1; data_rdata = rdata;
        @(negedge clk);
        chk({tag, "_vld_n1"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_inrdy_n1"}, {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({tag, "_vld_n2"}, {31'h0, out_valid}, 32'h1);
        chk({tag, "_result"}, final_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc", PC_out, 32'h1c00_0000);
        chk("rst_result", final_result, 32'h0);
        chk("rst_gr_we", {31'h0, gr_we_out}, 32'h0);
        chk("rst_in_ready_idle", {31'h0, in_ready}, 32'h1);

        // ld.b at byte 3, sign-extended
        load_txn("ldb", 8'h01, 32'h01c0_0003, 32'h8012_3456, 32'hffff_ff80);
        chk("ldb_dest", {27'h0, dest_out}, 32'd7);
        chk("ldb_gr_we", {31'h0, gr_we_out}, 32'h1);
        chk("ldb_pc", PC_out, 32'h1c00_1000);
        load_txn("ldh", 8'h02, 32'h01c0_0012, 32'h8001_0000, 32'hffff_8001);
        load_txn("ldhu", 8'h40, 32'h01c0_0022, 32'h8001_0000, 32'h0000_8001);
        load_txn("ldbu", 8'h20, 32'h01c0_0031, 32'h0000_f100, 32'h0000_00f1);
        gap(1);

        // st.h at offset 2
        @(posedge clk); #1;
        in_valid = 1; mem_op = 8'h10; mem_we = 1; result = 32'h1c00_0102;
        rkd_value = 32'h0000_abcd; data_addr_ok = 1;
        @(negedge clk);
        chk("sth_req", {31'h0, data_req}, 32'h1);
        chk("sth_wr", {31'h0, data_wr}, 32'h1);
        chk("sth_wstrb", {28'h0, data_wstrb}, 32'hc);
        chk("sth_wdata", data_wdata, 32'habcd_abcd);
        chk("sth_size", {30'h0, data_size}, 32'h1);
        @(posedge clk); #1;
        data_addr_ok = 0; data_data_ok = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("sth_vld", {31'h0, out_valid}, 32'h1);
        chk("sth_result", final_result, 32'h1c00_0102);
        chk("sth_gr_we", {31'h0, gr_we_out}, 32'h0);
        gap(1);

        // ld.w whose data returns while write-back is stalled for 3 cycles
        @(posedge clk); #1;
        in_valid = 1; mem_op = 8'h04; res_from_mem = 1; gr_we = 1; dest = 5'd3;
        result = 32'h1c00_0200; data_addr_ok = 1;
        @(posedge clk); #1;
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344; out_ready = 0;
        @(negedge clk);
        chk("hold_inrdy0", {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            data_data_ok = 0; data_rdata = 32'hffff_ffff;
            @(negedge clk);
            chk("hold_inrdy", {31'h0, in_ready}, 32'h0);
            chk("hold_noreq", {31'h0, data_req}, 32'h0);
            chk("hold_vld", {31'h0, out_valid}, 32'h0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        chk("hold_release", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("hold_vld_out", {31'h0, out_valid}, 32'h1);
        chk("hold_result", final_result, 32'h1122_3344);
        gap(1);

        // ertn_flush while waiting for data: drain and drop the late response
        @(posedge clk); #1;
        in_valid = 1; mem_op = 8'h04; res_from_mem = 1; gr_we = 1;
        result = 32'h1c00_0300; data_addr_ok = 1;
        @(posedge clk); #1;
        data_addr_ok = 0; ertn_flush = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("drain_inrdy", {31'h0, in_ready}, 32'h0);
        chk("drain_vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        data_data_ok = 1; data_rdata = 32'hdead_beef;
        @(negedge clk);
        chk("drain_inrdy_ok", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("drain_vld_after", {31'h0, out_valid}, 32'h0);
        chk("drain_idle", {31'h0, in_ready}, 32'h1);
        gap(1);

        // exception on a load: no request, fields pass through
        @(posedge clk); #1;
        in_valid = 1; mem_op = 8'h04; res_from_mem = 1; gr_we = 1; has_exception = 1;
        ecode = 6'h08; esubcode = 9'h001; exception_maddr = 32'h1c00_0401;
        result = 32'h1c00_0401; PC = 32'h1c00_0040; data_addr_ok = 1;
        @(negedge clk);
        chk("exc_noreq", {31'h0, data_req}, 32'h0);
        chk("exc_this", {31'h0, this_exception}, 32'h1);
        chk("exc_inrdy", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("exc_vld", {31'h0, out_valid}, 32'h1);
        chk("exc_flag", {31'h0, has_exception_out}, 32'h1);
        chk("exc_ecode", {26'h0, ecode_out}, 32'h08);
        chk("exc_esub", {23'h0, esubcode_out}, 32'h001);
        chk("exc_maddr", exception_maddr_out, 32'h1c00_0401);
        chk("exc_gr_we", {31'h0, gr_we_out}, 32'h0);
        gap(1);

        // mulh.wu with the response arriving after 4 cycles
        @(posedge clk); #1;
        in_valid = 1; mul_op = 3'b100; res_from_mul = 1; gr_we = 1; result = 32'h0000_1234;
        mul_resp = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mul_stall", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        mul_resp_valid = 1;
        @(negedge clk);
        chk("mul_inrdy", {31'h0, in_ready}, 32'h1);
        chk("mul_rsp_rdy", {31'h0, mul_resp_ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("mul_vld", {31'h0, out_valid}, 32'h1);
        chk("mul_result", final_result, 32'h0000_0001);
        gap(1);

        // mod.w takes the remainder
        @(posedge clk); #1;
        in_valid = 1; div_op = 4'b0010; res_from_div = 1; gr_we = 1;
        div_resp_valid = 1; div_quot = 32'h0000_0005; div_rem = 32'h0000_0007;
        @(negedge clk);
        chk("div_rsp_rdy", {31'h0, div_resp_ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("div_result", final_result, 32'h0000_0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
